// File: rtl/mm2s_rd_engine_pkg.sv
// mm2s_pkg: shared FSM state type and AXI constants for the MM2S read engine
package mm2s_pkg;
  typedef enum logic [2:0] {IDLE, CALC, CREDIT, ADDR, DRAIN} state_e;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY = 2'b00;
  localparam int PAGE_BYTES = 4096;
endpackage

// File: rtl/mm2s_rd_engine_if.sv
// mm2s_rd_engine_if: command, AXI4 AR/R and FIFO write-side bundle
// master = engine side, slave = command source / AXI slave / FIFO side.
interface mm2s_rd_engine_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int LEN_W = 16,
  parameter int FIFO_ADDR_SZ = 5
);
  logic cmd_valid;
  logic cmd_ready;
  logic [ADDR_W-1:0] cmd_addr;
  logic [LEN_W-1:0] cmd_beats;
  logic [ADDR_W-1:0] m_araddr;
  logic [7:0] m_arlen;
  logic [2:0] m_arsize;
  logic [1:0] m_arburst;
  logic m_arvalid;
  logic m_arready;
  logic [DATA_W-1:0] m_rdata;
  logic [1:0] m_rresp;
  logic m_rlast;
  logic m_rvalid;
  logic m_rready;
  logic fifo_wr;
  logic [DATA_W-1:0] fifo_data;
  logic fifo_full;
  logic [FIFO_ADDR_SZ:0] fifo_count;
  modport master (
    input cmd_valid, cmd_addr, cmd_beats, m_arready, m_rdata, m_rresp, m_rlast, m_rvalid, fifo_full, fifo_count,
    output cmd_ready, m_araddr, m_arlen, m_arsize, m_arburst, m_arvalid, m_rready, fifo_wr, fifo_data
  );
  modport slave (
    output cmd_valid, cmd_addr, cmd_beats, m_arready, m_rdata, m_rresp, m_rlast, m_rvalid, fifo_full, fifo_count,
    input cmd_ready, m_araddr, m_arlen, m_arsize, m_arburst, m_arvalid, m_rready, fifo_wr, fifo_data
  );
endinterface

// File: rtl/mm2s_rd_engine_burst_calc.sv
// mm2s_burst_calc: burst length = min(remaining, MAX_BURST, beats left in 4 KB page)
// page_off_i: addr[11:0]; remaining_i: beats still to request; blen_o: beats for next AR.
module mm2s_burst_calc
  import mm2s_pkg::*;
#(
  parameter int LEN_W = 16,
  parameter int MAX_BURST = 16,
  parameter int BEAT_BYTES = 4
) (
  input  logic [11:0] page_off_i,
  input  logic [LEN_W-1:0] remaining_i,
  output logic [8:0] blen_o
);
  localparam int SZ = $clog2(BEAT_BYTES);
  logic [31:0] rem;
  logic [31:0] page;
  assign rem = 32'(remaining_i) < 32'(MAX_BURST) ? 32'(remaining_i) : 32'(MAX_BURST);
  assign page = (32'(PAGE_BYTES) - 32'(page_off_i)) >> SZ;
  assign blen_o = 9'(rem < page ? rem : page);
endmodule

// File: rtl/mm2s_rd_engine.sv
// mm2s_rd_engine: AXI4 read master splitting one command into credit-gated INCR bursts into a FIFO
// clk/reset_n: clock, async active-low reset; bus: cmd + AR/R + FIFO write side (master modport);
// busy/done/err: status. Optional MM2S_STATS_EN adds stat_bursts and stat_credit_stalls.
module mm2s_rd_engine
  import mm2s_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int LEN_W = 16,
  parameter int MAX_BURST = 16,
  parameter int FIFO_ADDR_SZ = 5
) (
  input  logic clk,
  input  logic reset_n,
  mm2s_rd_engine_if.master bus,
  output logic busy,
  output logic done,
  output logic err
`ifdef MM2S_STATS_EN
  ,
  output logic [31:0] stat_bursts,
  output logic [31:0] stat_credit_stalls
`endif
);
  localparam int BEAT_BYTES = DATA_W / 8;
  localparam int SZ = $clog2(BEAT_BYTES);
  localparam int DEPTH = 1 << FIFO_ADDR_SZ;
  localparam int RW = FIFO_ADDR_SZ + 1;
  state_e state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d, araddr_q, araddr_d;
  logic [LEN_W-1:0] rem_q, rem_d;
  logic [8:0] blen_q, blen_d, blen_c;
  logic [RW-1:0] rsv_q, rsv_d;
  logic [7:0] arlen_q, arlen_d;
  logic arvalid_q, arvalid_d, err_q, err_d;
  logic r_acc, ar_hs, credit_ok;
  logic unused_rlast;
  mm2s_burst_calc #(.LEN_W(LEN_W), .MAX_BURST(MAX_BURST), .BEAT_BYTES(BEAT_BYTES)) u_calc (
    .page_off_i(addr_q[11:0]),
    .remaining_i(rem_q),
    .blen_o(blen_c)
  );
  assign unused_rlast = bus.m_rlast;
  assign bus.cmd_ready = state_q == IDLE;
  assign bus.m_araddr = araddr_q;
  assign bus.m_arlen = arlen_q;
  assign bus.m_arsize = 3'(SZ);
  assign bus.m_arburst = AXI_BURST_INCR;
  assign bus.m_arvalid = arvalid_q;
  assign bus.m_rready = !bus.fifo_full;
  assign r_acc = bus.m_rvalid && bus.m_rready;
  // beats with nothing reserved are strays (e.g. after reset) and never reach the FIFO
  assign bus.fifo_wr = r_acc && rsv_q != '0;
  assign bus.fifo_data = bus.m_rdata;
  assign ar_hs = arvalid_q && bus.m_arready;
  // free space must cover beats already in flight plus the new burst
  assign credit_ok = 32'(DEPTH) - 32'(bus.fifo_count) >= 32'(rsv_q) + 32'(blen_q);
  assign busy = state_q != IDLE;
  assign done = state_q == DRAIN && rsv_q == '0;
  assign err = err_q;
  always_comb begin
    state_d = state_q;
    addr_d = addr_q;
    rem_d = rem_q;
    blen_d = blen_q;
    araddr_d = araddr_q;
    arlen_d = arlen_q;
    arvalid_d = arvalid_q;
    err_d = err_q | (r_acc && (bus.m_rresp != AXI_RESP_OKAY || rsv_q == '0));
    rsv_d = rsv_q + (ar_hs ? RW'(blen_q) : RW'(0)) - RW'(bus.fifo_wr);
    case (state_q)
      IDLE: if (bus.cmd_valid) begin
        addr_d = bus.cmd_addr & ~ADDR_W'(BEAT_BYTES - 1);
        rem_d = bus.cmd_beats;
        err_d = 1'b0;
        state_d = CALC;
      end
      CALC: begin
        blen_d = blen_c;
        state_d = rem_q == '0 ? DRAIN : CREDIT;
      end
      CREDIT: if (credit_ok) begin
        araddr_d = addr_q;
        arlen_d = 8'(blen_q - 9'd1);
        arvalid_d = 1'b1;
        state_d = ADDR;
      end
      ADDR: if (bus.m_arready) begin
        arvalid_d = 1'b0;
        addr_d = addr_q + (ADDR_W'(blen_q) << SZ);
        rem_d = rem_q - LEN_W'(blen_q);
        state_d = CALC;
      end
      DRAIN: state_d = rsv_q == '0 ? IDLE : DRAIN;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      addr_q <= '0;
      rem_q <= '0;
      blen_q <= '0;
      rsv_q <= '0;
      araddr_q <= '0;
      arlen_q <= '0;
      arvalid_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q <= addr_d;
      rem_q <= rem_d;
      blen_q <= blen_d;
      rsv_q <= rsv_d;
      araddr_q <= araddr_d;
      arlen_q <= arlen_d;
      arvalid_q <= arvalid_d;
      err_q <= err_d;
    end
  end
`ifdef MM2S_STATS_EN
  logic [31:0] bursts_q, stalls_q;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bursts_q <= '0;
      stalls_q <= '0;
    end else begin
      if (ar_hs && !(&bursts_q)) bursts_q <= bursts_q + 32'd1;
      if (state_q == CREDIT && !credit_ok && !(&stalls_q)) stalls_q <= stalls_q + 32'd1;
    end
  end
  assign stat_bursts = bursts_q;
  assign stat_credit_stalls = stalls_q;
`endif
endmodule

// File: tb/tb_mm2s_rd_engine.sv
// tb_mm2s_rd_engine: directed self-checking bench for mm2s_rd_engine with a simple AXI read slave model
module tb_mm2s_rd_engine;
  logic clk = 1'b0;
  logic reset_n;
  logic busy, done, err;
  int vecs = 0;
  int miss = 0;
  logic r_en, ar_rdy;
  int err_beat;
  int pending = 0;
  int ar_count = 0;
  int wr_count = 0;
  int done_count = 0;
  int beat_idx = 0;
  logic [31:0] ar_addr_log [0:31];
  logic [7:0] ar_len_log [0:31];
  mm2s_rd_engine_if #(.ADDR_W(32), .DATA_W(32), .LEN_W(16), .FIFO_ADDR_SZ(5)) bus ();
`ifdef MM2S_STATS_EN
  logic [31:0] stat_bursts, stat_credit_stalls;
`endif
  mm2s_rd_engine #(.ADDR_W(32), .DATA_W(32), .LEN_W(16), .MAX_BURST(16), .FIFO_ADDR_SZ(5)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus),
    .busy(busy),
    .done(done),
    .err(err)
`ifdef MM2S_STATS_EN
    ,
    .stat_bursts(stat_bursts),
    .stat_credit_stalls(stat_credit_stalls)
`endif
  );
  always #5 clk = ~clk;
  assign bus.m_arready = ar_rdy;
  assign bus.m_rvalid = r_en && pending != 0;
  assign bus.m_rdata = 32'(beat_idx);
  assign bus.m_rresp = beat_idx == err_beat ? 2'b10 : 2'b00;
  assign bus.m_rlast = pending == 1;
  always @(posedge clk) begin
    if (bus.m_arvalid && bus.m_arready) begin
      ar_addr_log[ar_count] <= bus.m_araddr;
      ar_len_log[ar_count] <= bus.m_arlen;
      ar_count <= ar_count + 1;
    end
    pending <= pending + ((bus.m_arvalid && bus.m_arready) ? int'(bus.m_arlen) + 1 : 0)
               - ((bus.m_rvalid && bus.m_rready) ? 1 : 0);
    if (bus.m_rvalid && bus.m_rready) beat_idx <= beat_idx + 1;
    if (bus.fifo_wr) wr_count <= wr_count + 1;
    if (done) done_count <= done_count + 1;
  end
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vecs++;
    assert (got === exp) else begin
      miss++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic send_cmd(input logic [31:0] a, input logic [15:0] n);
    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_addr = a;
    bus.cmd_beats = n;
    @(posedge clk);
    #1 bus.cmd_valid = 1'b0;
  endtask
  task automatic wait_done(input string tag);
    int n = 0;
    while (!done && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 64'(done), 64'd1);
  endtask
  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  initial begin
    int ab, wb, db, n;
`ifdef MM2S_STATS_EN
    logic [31:0] s0;
`endif
    reset_n = 1'b0;
    r_en = 1'b1;
    ar_rdy = 1'b1;
    err_beat = -1;
    bus.cmd_valid = 1'b0;
    bus.cmd_addr = '0;
    bus.cmd_beats = '0;
    bus.fifo_full = 1'b0;
    bus.fifo_count = '0;
    @(negedge clk);
    chk("rst_cmd_ready", 64'(bus.cmd_ready), 64'd1);
    chk("rst_arvalid", 64'(bus.m_arvalid), 64'd0);
    chk("rst_araddr", 64'(bus.m_araddr), 64'd0);
    chk("rst_arlen", 64'(bus.m_arlen), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    chk("arsize", 64'(bus.m_arsize), 64'd2);
    chk("arburst", 64'(bus.m_arburst), 64'd1);
    @(negedge clk);
    reset_n = 1'b1;
    // 40 beats from 0: bursts of 16, 16, 8
    ab = ar_count; wb = wr_count; db = done_count;
    send_cmd(32'h0, 16'd40);
    chk("t1_busy", 64'(busy), 64'd1);
    n = 0;
    while (!bus.fifo_wr && n < 50) begin @(negedge clk); n++; end
    chk("t1_fifo_wr", 64'(bus.fifo_wr), 64'd1);
    chk("t1_fifo_data", 64'(bus.fifo_data), 64'(beat_idx));
    wait_done("t1_done");
    @(posedge clk); @(negedge clk);
    chk("t1_ar_count", 64'(ar_count - ab), 64'd3);
    chk("t1_ar0_addr", 64'(ar_addr_log[ab]), 64'h0);
    chk("t1_ar0_len", 64'(ar_len_log[ab]), 64'd15);
    chk("t1_ar1_addr", 64'(ar_addr_log[ab+1]), 64'h40);
    chk("t1_ar1_len", 64'(ar_len_log[ab+1]), 64'd15);
    chk("t1_ar2_addr", 64'(ar_addr_log[ab+2]), 64'h80);
    chk("t1_ar2_len", 64'(ar_len_log[ab+2]), 64'd7);
    chk("t1_wr_count", 64'(wr_count - wb), 64'd40);
    chk("t1_err", 64'(err), 64'd0);
    chk("t1_busy_end", 64'(busy), 64'd0);
    repeat (3) @(negedge clk);
    chk("t1_done_once", 64'(done_count - db), 64'd1);
    // 4 KB page crossing split
    ab = ar_count; wb = wr_count;
    send_cmd(32'hFF8, 16'd8);
    wait_done("t2_done");
    @(posedge clk); @(negedge clk);
    chk("t2_ar_count", 64'(ar_count - ab), 64'd2);
    chk("t2_ar0_addr", 64'(ar_addr_log[ab]), 64'hFF8);
    chk("t2_ar0_len", 64'(ar_len_log[ab]), 64'd1);
    chk("t2_ar1_addr", 64'(ar_addr_log[ab+1]), 64'h1000);
    chk("t2_ar1_len", 64'(ar_len_log[ab+1]), 64'd5);
    chk("t2_wr_count", 64'(wr_count - wb), 64'd8);
    // credit stall: 32-20=12 free < 16
    bus.fifo_count = 6'd20;
    ab = ar_count; wb = wr_count;
    send_cmd(32'h200, 16'd16);
    repeat (3) @(negedge clk);
`ifdef MM2S_STATS_EN
    s0 = stat_credit_stalls;
`endif
    repeat (5) @(negedge clk);
    chk("t3_no_ar", 64'(ar_count - ab), 64'd0);
    chk("t3_arvalid", 64'(bus.m_arvalid), 64'd0);
    chk("t3_busy", 64'(busy), 64'd1);
`ifdef MM2S_STATS_EN
    chk("t3_stalls", 64'(stat_credit_stalls - s0), 64'd5);
`endif
    bus.fifo_full = 1'b1;
    #1 chk("t3_rready_full", 64'(bus.m_rready), 64'd0);
    bus.fifo_full = 1'b0;
    bus.fifo_count = 6'd16;
    wait_done("t3_done");
    @(posedge clk); @(negedge clk);
    bus.fifo_count = '0;
    chk("t3_ar_count", 64'(ar_count - ab), 64'd1);
    chk("t3_ar_addr", 64'(ar_addr_log[ab]), 64'h200);
    chk("t3_ar_len", 64'(ar_len_log[ab]), 64'd15);
    chk("t3_wr_count", 64'(wr_count - wb), 64'd16);
    // SLVERR on one beat mid-transfer
    wb = wr_count;
    err_beat = beat_idx + 3;
    send_cmd(32'h300, 16'd8);
    wait_done("t4_done");
    chk("t4_err_at_done", 64'(err), 64'd1);
    @(posedge clk); @(negedge clk);
    err_beat = -1;
    chk("t4_wr_count", 64'(wr_count - wb), 64'd8);
    chk("t4_err_sticky", 64'(err), 64'd1);
    // zero-beat command
    ab = ar_count;
    send_cmd(32'h400, 16'd0);
    @(negedge clk);
    chk("t5_busy", 64'(busy), 64'd1);
    chk("t5_err_cleared", 64'(err), 64'd0);
    chk("t5_done_early", 64'(done), 64'd0);
    @(negedge clk);
    chk("t5_done", 64'(done), 64'd1);
    @(negedge clk);
    chk("t5_done_off", 64'(done), 64'd0);
    chk("t5_cmd_ready", 64'(bus.cmd_ready), 64'd1);
    chk("t5_no_ar", 64'(ar_count - ab), 64'd0);
    // reset while in ADDR with 8 beats reserved
    r_en = 1'b0;
    ab = ar_count;
    send_cmd(32'hFE0, 16'd24);
    n = 0;
    while (ar_count == ab && n < 50) begin @(negedge clk); n++; end
    ar_rdy = 1'b0;
    chk("t6_first_ar_len", 64'(ar_len_log[ab]), 64'd7);
    repeat (4) @(negedge clk);
    chk("t6_arvalid_held", 64'(bus.m_arvalid), 64'd1);
    chk("t6_araddr", 64'(bus.m_araddr), 64'h1000);
    chk("t6_arlen", 64'(bus.m_arlen), 64'd15);
    #2 reset_n = 1'b0;
    #1;
    chk("t6_rst_arvalid", 64'(bus.m_arvalid), 64'd0);
    chk("t6_rst_busy", 64'(busy), 64'd0);
    chk("t6_rst_cmd_ready", 64'(bus.cmd_ready), 64'd1);
    @(negedge clk);
    reset_n = 1'b1;
    ar_rdy = 1'b1;
    r_en = 1'b1;
    wb = wr_count;
    repeat (12) @(negedge clk);
    chk("t6_stray_dropped", 64'(wr_count - wb), 64'd0);
    chk("t6_idle", 64'(busy), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end
endmodule

// File: doc/mm2s_rd_engine.md
Name: mm2s_rd_engine

Overview:
- AXI4 read master feeding the stream FIFO from the write side (upstream stage of the FIFO).
- Accepts one transfer command (start address, beat count) and splits it into INCR bursts.
- Bursts never cross a 4 KB boundary and never exceed MAX_BURST beats.
- Issues an AR burst only when FIFO free space covers every outstanding beat plus the new burst, so R data is never back-pressured by the FIFO.

Parameters:
- ADDR_W, 32, AXI address width.
- DATA_W, 32, AXI/FIFO data width; power of two, 8..1024.
- LEN_W, 16, width of command beat count.
- MAX_BURST, 16, max beats per AR burst; 1..256, must be ≤ FIFO depth.
- FIFO_ADDR_SZ, 5, log2 of downstream FIFO depth (depth = 1<<FIFO_ADDR_SZ).

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- cmd_valid  in  1  command valid
- cmd_ready  out  1  engine idle, command accepted on valid&&ready
- cmd_addr  in  ADDR_W  byte start address, beat-aligned
- cmd_beats  in  LEN_W  beats to read
- m_araddr  out  ADDR_W  AR address
- m_arlen  out  8  beats-1
- m_arsize  out  3  log2(DATA_W/8)
- m_arburst  out  2  constant INCR (2'b01)
- m_arvalid  out  1  AR valid
- m_arready  in  1  AR ready
- m_rdata  in  DATA_W  read data
- m_rresp  in  2  read response
- m_rlast  in  1  last beat of burst
- m_rvalid  in  1  R valid
- m_rready  out  1  R ready
- fifo_wr  out  1  FIFO write strobe
- fifo_data  out  DATA_W  FIFO write data
- fifo_full  in  1  FIFO full
- fifo_count  in  FIFO_ADDR_SZ+1  FIFO occupancy
- busy  out  1  command in progress
- done  out  1  one-cycle pulse on completion
- err  out  1  sticky: some rresp != OKAY; cleared on next command accept

Behaviour:
- Reset values: cmd_ready=1, m_arvalid=0, m_araddr=0, m_arlen=0, busy=0, done=0, err=0, all counters 0, state IDLE.
- Fixed outputs: m_arsize and m_arburst are constant. The low log2(DATA_W/8) bits of cmd_addr are forced to zero.
- FSM states:
  - IDLE: cmd_ready=1. On accept, latch addr/beats, clear err, go CALC.
  - CALC, one cycle: blen = min(remaining, MAX_BURST, (4096 - addr[11:0]) / BEAT_BYTES). If remaining == 0, go DRAIN; else go CREDIT.
  - CREDIT: stay until (DEPTH - fifo_count) ≥ reserved + blen. Then register m_araddr=addr, m_arlen=blen-1, assert m_arvalid, go ADDR.
  - ADDR: hold m_arvalid and AR fields stable until m_arready. On handshake: reserved += blen, addr += blen*BEAT_BYTES, remaining -= blen, go CALC.
  - DRAIN: wait reserved == 0, then pulse done, go IDLE.
- R path: m_rready = !fifo_full. fifo_wr = m_rvalid && m_rready (combinational pass-through). fifo_data = m_rdata. Each accepted beat decrements reserved.
- Simultaneous events: an AR handshake and an R beat in the same cycle update reserved by +blen-1.
- reserved is FIFO_ADDR_SZ+1 bits and never exceeds DEPTH.
- err: set on any accepted beat with m_rresp != 2'b00. The data beat is still written.
- m_rlast is not used for counting. A beat arriving with reserved == 0 is dropped (not written) and sets err.
- cmd_beats == 0: accepted, CALC→DRAIN, done pulses 2 cycles after accept, no AR issued.
- busy = (state != IDLE).
- Reset mid-operation: returns to IDLE immediately. Outstanding R beats arriving after reset are dropped. The external system must also reset the FIFO and interconnect.

Optional Feature:
- Macro: MM2S_STATS_EN.
- When defined, adds outputs stat_bursts (32 b, AR handshakes) and stat_credit_stalls (32 b, cycles in CREDIT with the condition false). Both clear on reset only and saturate at all-ones.
- When undefined, these ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Package mm2s_pkg:
  - state enum typedef (IDLE, CALC, CREDIT, ADDR, DRAIN)
  - AXI_BURST_INCR = 2'b01
  - AXI_RESP_OKAY = 2'b00
  - PAGE_BYTES = 4096
- Sub-module mm2s_burst_calc: combinational blen from addr/remaining/MAX_BURST. It is registered in CALC by the parent.

Test Plan:
- cmd addr=0x0, beats=40, MAX_BURST=16, arready/rvalid always 1, FIFO drained each cycle -> three ARs with arlen 15, 15, 7 at 0x0, 0x40, 0x80; 40 fifo_wr; done pulses once.
- cmd addr=0xFF8 (DATA_W=32), beats=8 -> ARs at 0xFF8 arlen=1, then 0x1000 arlen=5; no 4 KB crossing.
- FIFO depth 32, fifo_count held at 20, beats=16 -> no AR until fifo_count ≤ 16; stat_credit_stalls increments each stalled cycle when MM2S_STATS_EN is defined.
- One beat with rresp=2'b10 mid-transfer -> that beat is still written, err=1 through done; next cmd accept clears err.
- cmd beats=0 -> no AR, done 2 cycles after accept, cmd_ready back high.
- reset_n asserted while in ADDR with 8 beats reserved -> m_arvalid=0, busy=0, cmd_ready=1 asynchronously; later R beats produce no fifo_wr.
